tx_riffa_axi: RTL and testbench

- Host-to-card DMA stage: consumes one RIFFA RX channel transaction per packet and emits one AXI4-Stream master packet toward the NetFPGA datapath.
- Counterpart of the card-to-host AXIS→RIFFA stage. The first 128-bit beat of every transaction is a packet header in the same layout that stage produces.
- The header is validated and stripped; its metadata is forwarded on tuser, and the payload is forwarded with tkeep and tlast derived from the header length.

---
 rtl/tx_riffa_axi_pkg.sv | 38 +++
 rtl/tx_riffa_axi_if.sv | 41 ++++
 rtl/fallthrough_small_fifo.sv | 56 +++++
 rtl/tx_riffa_axi.sv | 191 +++++++++++++++++++
 tb/tb_tx_riffa_axi.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_riffa_axi_pkg.sv
// Shared definitions for the host-to-card RIFFA -> AXI4-Stream stage:
// header/tuser field offsets, defaults, FSM states and the tail-keep helper.
package tx_riffa_axi_pkg;

    localparam int PCI_DW = 128;
    localparam int KEEP_W = PCI_DW / 8;

    localparam logic [15:0] DEF_PREAM_VALUE  = 16'hCAFE;
    localparam int          DEF_MAX_PKT_SIZE = 2000;

    // Header beat layout, identical to what the card-to-host stage emits.
    localparam int HDR_PREAM_LSB = 48;
    localparam int HDR_LEN_LSB   = 32;
    localparam int HDR_DST_LSB   = 16;
    localparam int HDR_SRC_LSB   = 0;

    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_SRC_LSB = 16;
    localparam int TUSER_DST_LSB = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [PCI_DW-1:0] data;
    } data_beat_t;

    function automatic logic [KEEP_W-1:0] last_keep(input logic [3:0] rem);
        last_keep = (rem == 4'd0) ? '1 : KEEP_W'((17'd1 << rem) - 17'd1);
    endfunction

endpackage

// File: rtl/tx_riffa_axi_if.sv
// RIFFA RX channel and AXI4-Stream bundles; master drives the transfer,
// slave answers with ACK/REN or tready.
interface riffa_rx_if;
    logic         CHNL_RX;
    logic         CHNL_RX_LAST;
    logic [31:0]  CHNL_RX_LEN;
    logic [30:0]  CHNL_RX_OFF;
    logic [127:0] CHNL_RX_DATA;
    logic         CHNL_RX_DATA_VALID;
    logic         CHNL_RX_ACK;
    logic         CHNL_RX_DATA_REN;

    modport master (
        output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
               CHNL_RX_DATA, CHNL_RX_DATA_VALID,
        input  CHNL_RX_ACK, CHNL_RX_DATA_REN
    );
    modport slave (
        input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
               CHNL_RX_DATA, CHNL_RX_DATA_VALID,
        output CHNL_RX_ACK, CHNL_RX_DATA_REN
    );
endinterface

interface axis_if;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;

    modport master (
        output m_tdata, m_tkeep, m_tuser, m_tvalid, m_tlast,
        input  m_tready
    );
    modport slave (
        input  m_tdata, m_tkeep, m_tuser, m_tvalid, m_tlast,
        output m_tready
    );
endinterface

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is visible on dout_o
// whenever empty_o is low, so a pop costs no extra cycle.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             nearly_full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] FULL_CNT = {1'b1, {MAX_DEPTH_BITS{1'b0}}};
    localparam logic [MAX_DEPTH_BITS:0] NEAR_CNT = FULL_CNT - 1'b1;

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [MAX_DEPTH_BITS:0]   count_q;
    logic                      do_wr, do_rd;

    assign do_wr         = wr_en_i && !full_o;
    assign do_rd         = rd_en_i && !empty_o;
    assign full_o        = (count_q == FULL_CNT);
    assign nearly_full_o = (count_q >= NEAR_CNT);
    assign empty_o       = (count_q == '0);
    assign dout_o        = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; only pointers and count define validity,
    // so flushing them is enough and the array maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tx_riffa_axi.sv
// Host-to-card DMA stage: one RIFFA RX transaction in, one AXI4-Stream
// packet out; the header beat is validated, stripped and sent on tuser.
module tx_riffa_axi
    import tx_riffa_axi_pkg::*;
#(
    parameter int          C_PCI_DATA_WIDTH     = PCI_DW,
    parameter logic [15:0] C_PREAM_VALUE        = DEF_PREAM_VALUE,
    parameter int          MAX_PKT_SIZE         = DEF_MAX_PKT_SIZE,
    parameter int          DATA_FIFO_DEPTH_BITS = 7,
    parameter int          META_FIFO_DEPTH_BITS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    riffa_rx_if.slave   rx,
    axis_if.master      m,
    output logic [31:0] pkt_count,
    output logic [31:0] err_count
);

    localparam int DATA_W = C_PCI_DATA_WIDTH + C_PCI_DATA_WIDTH / 8 + 1;

    state_e       state_q;
    logic         ack_q;
    logic [31:0]  len_q, wcnt_q, err_q, pkt_q;
    logic [12:0]  bcnt_q;
    logic [3:0]   rem_q;

    logic         ren, accept, final_beat, hdr_ok;
    logic [31:0]  wcnt_d;
    logic [12:0]  bcnt_load;
    logic [15:0]  hdr_pre, hdr_plen;
    logic [7:0]   hdr_dst, hdr_src;

    logic         meta_push, meta_pop, meta_full, meta_empty;
    logic [127:0] meta_din, meta_head;
    logic         data_push, data_pop, data_nearly_full, data_empty;
    data_beat_t   data_din, data_head;
    logic         tvalid;
    logic         unused_meta_nfull, unused_data_full, unused_rx;

    assign unused_rx = &{1'b0, rx.CHNL_RX_LAST, rx.CHNL_RX_OFF};

    assign accept     = rx.CHNL_RX_DATA_VALID && ren;
    assign wcnt_d     = wcnt_q + 32'd4;
    assign final_beat = ({1'b0, wcnt_q} + 33'd4) >= {1'b0, len_q};

    assign hdr_pre   = rx.CHNL_RX_DATA[HDR_PREAM_LSB +: 16];
    assign hdr_plen  = rx.CHNL_RX_DATA[HDR_LEN_LSB +: 16];
    assign hdr_dst   = rx.CHNL_RX_DATA[HDR_DST_LSB +: 8];
    assign hdr_src   = rx.CHNL_RX_DATA[HDR_SRC_LSB +: 8];
    assign bcnt_load = 13'((32'(hdr_plen) + 32'd15) >> 4);
    // A header that is also the final beat leaves no room for payload.
    assign hdr_ok    = (hdr_pre == C_PREAM_VALUE) && (hdr_plen != 16'd0) &&
                       (32'(hdr_plen) <= 32'(MAX_PKT_SIZE)) && !final_beat;

    // NOTE: every branch of a combinational block must assign its outputs;
    // the leading default keeps ren from being inferred as a latch.
    always_comb begin
        ren = 1'b0;
        unique case (state_q)
            ST_HDR:   ren = !ack_q && !meta_full;
            ST_DATA:  ren = !data_nearly_full;
            ST_DRAIN: ren = 1'b1;
            default:  ren = 1'b0;
        endcase
    end

    always_comb begin
        meta_din                        = '0;
        meta_din[127:64]                = rx.CHNL_RX_DATA[127:64];
        meta_din[TUSER_DST_LSB +: 8]    = hdr_dst;
        meta_din[TUSER_SRC_LSB +: 8]    = hdr_src;
        meta_din[TUSER_LEN_LSB +: 16]   = hdr_plen;
    end

    assign meta_push     = (state_q == ST_HDR) && accept && hdr_ok;
    assign data_push     = (state_q == ST_DATA) && accept;
    assign data_din.data = rx.CHNL_RX_DATA;
    assign data_din.last = (bcnt_q == 13'd1) || final_beat;
    assign data_din.keep = (bcnt_q == 13'd1) ? last_keep(rem_q) : '1;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            len_q   <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            rem_q   <= '0;
            err_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rx.CHNL_RX && !ack_q) begin
                        ack_q  <= 1'b1;
                        len_q  <= rx.CHNL_RX_LEN;
                        wcnt_q <= '0;
                        if (rx.CHNL_RX_LEN != 32'd0) state_q <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        wcnt_q <= wcnt_d;
                        if (hdr_ok) begin
                            bcnt_q  <= bcnt_load;
                            rem_q   <= hdr_plen[3:0];
                            state_q <= ST_DATA;
                        end else begin
                            err_q   <= err_q + 32'd1;
                            state_q <= final_beat ? ST_IDLE : ST_DRAIN;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        wcnt_q <= wcnt_d;
                        bcnt_q <= bcnt_q - 13'd1;
                        if (final_beat) begin
                            if (bcnt_q > 13'd1) err_q <= err_q + 32'd1;
                            state_q <= ST_IDLE;
                        end else if (bcnt_q == 13'd1) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept) begin
                        wcnt_q <= wcnt_d;
                        if (final_beat) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    fallthrough_small_fifo #(
        .WIDTH          (128),
        .MAX_DEPTH_BITS (META_FIFO_DEPTH_BITS)
    ) u_meta_fifo (
        .clk           (CLK),
        .rst           (RST),
        .din_i         (meta_din),
        .wr_en_i       (meta_push),
        .rd_en_i       (meta_pop),
        .dout_o        (meta_head),
        .full_o        (meta_full),
        .nearly_full_o (unused_meta_nfull),
        .empty_o       (meta_empty)
    );

    fallthrough_small_fifo #(
        .WIDTH          (DATA_W),
        .MAX_DEPTH_BITS (DATA_FIFO_DEPTH_BITS)
    ) u_data_fifo (
        .clk           (CLK),
        .rst           (RST),
        .din_i         (data_din),
        .wr_en_i       (data_push),
        .rd_en_i       (data_pop),
        .dout_o        (data_head),
        .full_o        (unused_data_full),
        .nearly_full_o (data_nearly_full),
        .empty_o       (data_empty)
    );

    // Outputs are gated so nothing but zeros is shown while no beat is valid.
    assign tvalid     = !data_empty && !meta_empty;
    assign m.m_tvalid = tvalid;
    assign m.m_tdata  = tvalid ? data_head.data : '0;
    assign m.m_tkeep  = tvalid ? data_head.keep : '0;
    assign m.m_tlast  = tvalid && data_head.last;
    assign m.m_tuser  = tvalid ? meta_head : '0;

    assign data_pop = tvalid && m.m_tready;
    assign meta_pop = data_pop && data_head.last;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pkt_q <= '0;
        else if (meta_pop) pkt_q <= pkt_q + 32'd1;
    end

    assign rx.CHNL_RX_ACK      = ack_q;
    assign rx.CHNL_RX_DATA_REN = ren;
    assign pkt_count           = pkt_q;
    assign err_count           = err_q;

endmodule

// File: tb/tb_tx_riffa_axi.sv
// Self-checking bench for tx_riffa_axi: randomized host transactions are
// compared against a packet-level reference model of the header rules.
module tb_tx_riffa_axi;

    localparam logic [15:0] PREAM = 16'hCAFE;
    localparam int          MAXP  = 2000;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic [127:0] user;
    } beat_t;

    logic        clk, rst;
    logic [31:0] pkt_count, err_count;

    riffa_rx_if rx_if ();
    axis_if     ax_if ();

    tx_riffa_axi #(
        .C_PCI_DATA_WIDTH     (128),
        .C_PREAM_VALUE        (16'hCAFE),
        .MAX_PKT_SIZE         (2000),
        .DATA_FIFO_DEPTH_BITS (7),
        .META_FIFO_DEPTH_BITS (2)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .rx        (rx_if),
        .m         (ax_if),
        .pkt_count (pkt_count),
        .err_count (err_count)
    );

    int           total, bad;
    int           overlap, tvalid_seen;
    int           rdy_mode;
    int           exp_pkt, exp_err;
    beat_t        exp_q[$], got_q[$];
    logic [127:0] tx_beats[$];
    logic [127:0] first_user;
    logic [15:0]  final_keep;
    int           last_nbeats;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // tready changes shortly after each rising edge, well away from sampling.
    initial begin
        ax_if.m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       ax_if.m_tready = 1'b0;
                1:       ax_if.m_tready = 1'b1;
                2:       ax_if.m_tready = ~ax_if.m_tready;
                default: ax_if.m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.CHNL_RX_ACK && rx_if.CHNL_RX_DATA_REN) overlap++;
            if (ax_if.m_tvalid) tvalid_seen++;
            if (ax_if.m_tvalid && ax_if.m_tready)
                got_q.push_back('{ax_if.m_tdata, ax_if.m_tkeep, ax_if.m_tlast, ax_if.m_tuser});
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic make_txn(input logic [15:0] pre, input logic [15:0] plen,
                            input logic [7:0] dst, input logic [7:0] src, input int len);
        logic [127:0] hdr;
        tx_beats.delete();
        hdr         = rand128();
        hdr[63:48]  = pre;
        hdr[47:32]  = plen;
        hdr[23:16]  = dst;
        hdr[7:0]    = src;
        if (len > 0) tx_beats.push_back(hdr);
        for (int i = 1; i < (len + 3) / 4; i++) tx_beats.push_back(rand128());
    endtask

    // Packet-level view: how many payload beats fit, where the packet ends,
    // how many bytes the tail carries, and whether an error is recorded.
    function automatic void model_txn(input int len);
        int           nb, plen, need, avail, n, tail;
        logic [127:0] hdr;
        beat_t        b;
        nb = (len + 3) / 4;
        if (nb == 0) return;
        hdr  = tx_beats[0];
        plen = int'(hdr[47:32]);
        if (hdr[63:48] != PREAM || plen < 1 || plen > MAXP || nb < 2) begin
            exp_err++;
            return;
        end
        need  = (plen + 15) / 16;
        avail = nb - 1;
        n     = (need < avail) ? need : avail;
        tail  = plen - 16 * (need - 1);
        for (int i = 0; i < n; i++) begin
            b.data = tx_beats[1 + i];
            b.last = (i == n - 1);
            b.keep = (i == need - 1) ? 16'((32'h1 << tail) - 1) : 16'hFFFF;
            b.user = {hdr[127:64], 32'h0, hdr[23:16], hdr[7:0], hdr[47:32]};
            exp_q.push_back(b);
        end
        if (need > avail) exp_err++;
        exp_pkt++;
    endfunction

    task automatic host_txn(input int len, input int max_beats);
        int   nb, idx, cyc;
        logic seen;
        nb = (len + 3) / 4;
        if (max_beats < nb) nb = max_beats;
        @(posedge clk);
        #1;
        rx_if.CHNL_RX      = 1'b1;
        rx_if.CHNL_RX_LEN  = len;
        rx_if.CHNL_RX_OFF  = 31'($urandom);
        rx_if.CHNL_RX_LAST = 1'b1;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (rx_if.CHNL_RX_ACK) seen = 1'b1;
            cyc++;
        end
        rx_if.CHNL_RX = 1'b0;
        check("ack_pulse", seen, 1'b1);
        if (!seen) return;
        @(negedge clk);
        check("ack_one_cycle", rx_if.CHNL_RX_ACK, 1'b0);
        idx = 0;
        cyc = 0;
        while (idx < nb && cyc < 4000) begin
            @(posedge clk);
            #1;
            rx_if.CHNL_RX_DATA_VALID = ($urandom_range(0, 3) != 0);
            rx_if.CHNL_RX_DATA       = tx_beats[idx];
            @(negedge clk);
            if (rx_if.CHNL_RX_DATA_VALID && rx_if.CHNL_RX_DATA_REN) idx++;
            cyc++;
        end
        @(posedge clk);
        #1;
        rx_if.CHNL_RX_DATA_VALID = 1'b0;
        check("host_beats", idx, nb);
    endtask

    task automatic do_txn(input logic [15:0] pre, input logic [15:0] plen, input int len);
        make_txn(pre, plen, 8'($urandom), 8'($urandom), len);
        model_txn(len);
        host_txn(len, 1 << 20);
    endtask

    task automatic compare_batch(input string tag);
        int cyc;
        cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_nbeats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s_keep%0d", tag, i), got_q[i].keep, exp_q[i].keep);
            check($sformatf("%s_last%0d", tag, i), got_q[i].last, exp_q[i].last);
            check($sformatf("%s_user%0d", tag, i), got_q[i].user, exp_q[i].user);
        end
        check({tag, "_pkt_count"}, pkt_count, exp_pkt);
        check({tag, "_err_count"}, err_count, exp_err);
        last_nbeats = got_q.size();
        first_user  = (got_q.size() > 0) ? got_q[0].user : '0;
        final_keep  = (got_q.size() > 0) ? got_q[got_q.size() - 1].keep : '0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int s0, plen, need, len;
        total = 0; bad = 0; overlap = 0; tvalid_seen = 0;
        exp_pkt = 0; exp_err = 0; rdy_mode = 1;
        rst = 1'b1;
        rx_if.CHNL_RX = 1'b0; rx_if.CHNL_RX_LAST = 1'b0; rx_if.CHNL_RX_LEN = '0;
        rx_if.CHNL_RX_OFF = '0; rx_if.CHNL_RX_DATA = '0; rx_if.CHNL_RX_DATA_VALID = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", rx_if.CHNL_RX_ACK, 1'b0);
        check("rst_ren", rx_if.CHNL_RX_DATA_REN, 1'b0);
        check("rst_tvalid", ax_if.m_tvalid, 1'b0);
        check("rst_tdata", ax_if.m_tdata, '0);
        check("rst_tkeep", ax_if.m_tkeep, '0);
        check("rst_tlast", ax_if.m_tlast, 1'b0);
        check("rst_tuser", ax_if.m_tuser, '0);
        check("rst_pkt", pkt_count, '0);
        check("rst_err", err_count, '0);
        rst = 1'b0;

        // Good packet with fixed addressing.
        make_txn(PREAM, 16'd64, 8'h04, 8'h01, 20);
        model_txn(20);
        host_txn(20, 1 << 20);
        compare_batch("good");
        check("good_beats", last_nbeats, 4);
        check("good_tuser_lo", first_user[31:0], 32'h04010040);
        check("good_tail_keep", final_keep, 16'hFFFF);

        do_txn(PREAM, 16'd61, 20);
        compare_batch("partial");
        check("partial_tail_keep", final_keep, 16'h1FFF);

        s0 = tvalid_seen;
        do_txn(16'hBEEF, 16'd32, 12);
        compare_batch("bad_pre");
        check("bad_pre_no_tvalid", tvalid_seen - s0, 0);

        do_txn(PREAM, 16'd64, 8);
        compare_batch("trunc");
        check("trunc_beats", last_nbeats, 1);

        rdy_mode = 2;
        do_txn(PREAM, 16'd16, 16);
        do_txn(PREAM, 16'd40, 16);
        compare_batch("pad_bp");

        rdy_mode = 1;
        do_txn(PREAM, 16'd64, 0);
        compare_batch("empty");
        do_txn(PREAM, 16'd64, 4);
        compare_batch("hdr_only");
        do_txn(PREAM, 16'd0, 12);
        compare_batch("plen0");
        do_txn(PREAM, 16'd2001, 12);
        compare_batch("plen_big");
        rdy_mode = 3;
        do_txn(PREAM, 16'd2000, 504);
        compare_batch("plen_max");

        // Several headers queued while the sink is stalled.
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        do_txn(PREAM, 16'd20, 12);
        do_txn(PREAM, 16'd33, 16);
        do_txn(PREAM, 16'd48, 16);
        rdy_mode = 3;
        compare_batch("batch");

        for (int i = 0; i < 20; i++) begin
            plen = $urandom_range(1, 200);
            need = (plen + 15) / 16;
            len  = 4 * (1 + need) + $urandom_range(0, 16) - 8;
            if (len < 1) len = 1;
            rdy_mode = $urandom_range(1, 3);
            do_txn(($urandom_range(0, 7) == 0) ? 16'hBEEF : PREAM, 16'(plen), len);
            compare_batch("rand");
        end

        // Reset in the middle of a packet held inside the FIFOs.
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        make_txn(PREAM, 16'd64, 8'h04, 8'h01, 20);
        host_txn(20, 3);
        repeat (2) @(negedge clk);
        check("pre_rst_tvalid", ax_if.m_tvalid, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_tvalid", ax_if.m_tvalid, 1'b0);
        check("midrst_tdata", ax_if.m_tdata, '0);
        check("midrst_ren", rx_if.CHNL_RX_DATA_REN, 1'b0);
        check("midrst_ack", rx_if.CHNL_RX_ACK, 1'b0);
        check("midrst_pkt", pkt_count, '0);
        check("midrst_err", err_count, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); got_q.delete();
        exp_pkt = 0; exp_err = 0;
        rdy_mode = 1;
        do_txn(PREAM, 16'd64, 20);
        compare_batch("after_rst");

        check("ack_ren_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
